// File: rtl/spi_byte_phy.sv
// SPI mode-0 MSB-first byte serializer/deserializer with divider, clock stretch, abort, 0xFF wait filter.
// Latency: byte occupies 16*(Divider+1) Clk cycles plus any stretch; RxValid pulses on the first IDLE cycle.
// Backpressure: TxReady high only in IDLE; optional wait timeout enabled by `define SPI_PHY_TIMEOUT_EN.
module spi_byte_phy #(
    parameter int DIV_W         = 8,
    parameter int TIMEOUT_BYTES = 1024
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [7:0]       TxData,
    input  logic             TxValid,
    output logic             TxReady,
    input  logic             WaitMode,
    input  logic             Abort,
    input  logic [DIV_W-1:0] Divider,
    input  logic             ClockStretch,
    output logic [7:0]       RxData,
    output logic             RxValid,
    output logic             Busy,
    output logic             TimeoutErr,
    output logic             SPIDo,
    input  logic             SPIDi,
    output logic             SPIClk
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_q, div_q_nxt, div_cnt, div_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       tx_sh, tx_sh_nxt, rx_sh, rx_sh_nxt;
    logic             abort_pend, abort_pend_nxt;
    logic             do_nxt;
    logic             byte_done;
    logic             terminal;
    logic             abort_now;

    assign terminal = (div_cnt == div_q);
    assign abort_now = abort_pend | Abort;

    always_comb begin
        state_nxt      = state;
        div_q_nxt      = div_q;
        div_cnt_nxt    = div_cnt;
        bit_cnt_nxt    = bit_cnt;
        tx_sh_nxt      = tx_sh;
        rx_sh_nxt      = rx_sh;
        abort_pend_nxt = abort_pend;
        do_nxt         = SPIDo;
        byte_done      = 1'b0;
        case (state)
            IDLE: begin
                if (TxValid) begin
                    state_nxt      = LOW;
                    div_q_nxt      = Divider;
                    div_cnt_nxt    = '0;
                    bit_cnt_nxt    = '0;
                    tx_sh_nxt      = TxData;
                    do_nxt         = TxData[7];
                    abort_pend_nxt = 1'b0;
                end
            end
            LOW: begin
                // Abort wins over stretch; a low phase may be cut short.
                if (Abort) begin
                    state_nxt = IDLE;
                    do_nxt    = 1'b1;
                end else if (!terminal) begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end else if (!ClockStretch) begin
                    state_nxt   = HIGH;
                    div_cnt_nxt = '0;
                    rx_sh_nxt   = {rx_sh[6:0], SPIDi};
                end
            end
            HIGH: begin
                if (!terminal) begin
                    div_cnt_nxt    = div_cnt + 1'b1;
                    abort_pend_nxt = abort_now;
                end else begin
                    div_cnt_nxt    = '0;
                    abort_pend_nxt = 1'b0;
                    if (abort_now) begin
                        state_nxt = IDLE;
                        do_nxt    = 1'b1;
                    end else if (bit_cnt == 3'd7) begin
                        state_nxt = IDLE;
                        do_nxt    = 1'b1;
                        byte_done = 1'b1;
                    end else begin
                        state_nxt   = LOW;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        tx_sh_nxt   = {tx_sh[6:0], 1'b0};
                        do_nxt      = tx_sh[6];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SPIClk comes from its own flop so it cannot glitch on state decode.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            div_q      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            abort_pend <= 1'b0;
            SPIDo      <= 1'b1;
            SPIClk     <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_q      <= div_q_nxt;
            div_cnt    <= div_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tx_sh      <= tx_sh_nxt;
            rx_sh      <= rx_sh_nxt;
            abort_pend <= abort_pend_nxt;
            SPIDo      <= do_nxt;
            SPIClk     <= (state_nxt == HIGH);
        end
    end

    assign TxReady = (state == IDLE);
    assign Busy    = (state != IDLE);

    logic token;
    logic is_ff;
    logic filtering;
    logic timeout_hit;
    logic deliver;

    assign is_ff     = (rx_sh == 8'hFF);
    assign filtering = WaitMode & ~token;
    assign deliver   = byte_done & (~filtering | ~is_ff | timeout_hit);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RxData  <= 8'h00;
            RxValid <= 1'b0;
            token   <= 1'b0;
        end else begin
            RxValid <= deliver;
            if (deliver)
                RxData <= rx_sh;
            if (!WaitMode || Abort)
                token <= 1'b0;
            else if (byte_done && !is_ff)
                token <= 1'b1;
        end
    end

`ifdef SPI_PHY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BYTES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = filtering & is_ff & (to_cnt == TO_W'(TIMEOUT_BYTES));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            to_cnt     <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            TimeoutErr <= byte_done & timeout_hit;
            if (!WaitMode || Abort || deliver)
                to_cnt <= '0;
            else if (byte_done && filtering && is_ff)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign TimeoutErr  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_phy.sv
// Randomized scoreboard bench for spi_byte_phy: stimulus pushes expected bytes/timing, a monitor pops and compares.
module tb_spi_byte_phy;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [7:0]    TxData;
    logic          TxValid;
    logic          TxReady;
    logic          WaitMode;
    logic          Abort;
    logic [DW-1:0] Divider;
    logic          ClockStretch;
    logic [7:0]    RxData;
    logic          RxValid;
    logic          Busy;
    logic          TimeoutErr;
    logic          SPIDo;
    logic          SPIDi;
    logic          SPIClk;

    always #5 Clk = ~Clk;

    spi_byte_phy #(.DIV_W(DW), .TIMEOUT_BYTES(TO)) dut (
        .Clk(Clk), .Reset(Reset), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .WaitMode(WaitMode), .Abort(Abort), .Divider(Divider), .ClockStretch(ClockStretch),
        .RxData(RxData), .RxValid(RxValid), .Busy(Busy), .TimeoutErr(TimeoutErr),
        .SPIDo(SPIDo), .SPIDi(SPIDi), .SPIClk(SPIClk)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {logic [7:0] tx; int div; bit aborted; int len;} txe_t;
    typedef struct {logic [7:0] d; bit to;} rxe_t;
    txe_t tx_exp[$];
    rxe_t rx_exp[$];

    // Device model: presents MSB first, advances one bit per falling SPIClk.
    logic [7:0] dev_cur = 8'hFF;
    int         dev_idx = 8;
    int         rise_cnt = 0;
    int         nbits = 0;
    logic [7:0] mosi = 8'h00;

    always_comb SPIDi = (dev_idx < 8) ? dev_cur[3'(7 - dev_idx)] : 1'b1;
    always @(negedge SPIClk) dev_idx++;
    always @(posedge SPIClk) begin
        rise_cnt++;
        mosi = {mosi[6:0], SPIDo};
        nbits++;
    end

    // Monitor
    int   cyc = 0, start = 0, hi_len = 0;
    bit   busy_prev = 0, hp_bad = 0;
    txe_t mt;
    rxe_t mr;

    always @(negedge Clk) begin
        cyc++;
        if (Reset) begin
            busy_prev = 0;
            hi_len    = 0;
            hp_bad    = 0;
        end else begin
            if (SPIClk) hi_len++;
            else if (hi_len > 0) begin
                if (tx_exp.size() == 0 || hi_len != tx_exp[0].div + 1) hp_bad = 1;
                hi_len = 0;
            end
            if (Busy && !busy_prev) begin
                start  = cyc;
                hp_bad = 0;
            end
            if (!Busy && busy_prev) begin
                chk("tx_expected", tx_exp.size() != 0, 1);
                if (tx_exp.size() != 0) begin
                    mt = tx_exp.pop_front();
                    chk("byte_len", cyc - start, mt.len);
                    chk("half_period_bad", hp_bad, 0);
                    chk("idle_sclk", SPIClk, 0);
                    if (!mt.aborted) begin
                        chk("mosi_bits", nbits, 8);
                        chk("mosi_data", mosi, mt.tx);
                        chk("idle_spido", SPIDo, 1);
                    end
                end
            end
            if (RxValid) begin
                chk("rx_expected", rx_exp.size() != 0, 1);
                if (rx_exp.size() != 0) begin
                    mr = rx_exp.pop_front();
                    chk("rx_data", RxData, mr.d);
                    chk("timeout_err", TimeoutErr, mr.to);
                end
            end else if (TimeoutErr) begin
                chk("timeout_needs_rxvalid", RxValid, 1);
            end
            busy_prev = Busy;
        end
    end

    // Reference model state
    bit m_token = 0;
    int m_cnt   = 0;
    bit m_wm    = 0;
    int m_div   = 0;

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (!Busy && tx_exp.size() == 0 && rx_exp.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain", ok, 1);
        @(posedge Clk); #1;
    endtask

    task automatic begin_group(input int div, input bit wm);
        drain();
        Divider  = DW'(div);
        WaitMode = wm;
        m_div    = div;
        m_wm     = wm;
        if (!wm) begin
            m_token = 0;
            m_cnt   = 0;
        end
    endtask

    task automatic idle_abort();
        drain();
        Abort = 1;
        @(posedge Clk); #1;
        Abort = 0;
        m_token = 0;
        m_cnt   = 0;
        @(negedge Clk);
        chk("idle_abort_busy", Busy, 0);
    endtask

    task automatic poll(input bit use_rise, input int target);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge Clk); #1;
            if ((use_rise ? rise_cnt : dev_idx) >= target) begin
                ok = 1;
                break;
            end
        end
        chk("phase_reached", ok, 1);
    endtask

    // mode: 0 plain, 1 stretch 3rd low phase for 10 cycles, 2 abort in 5th high phase
    task automatic send(input logic [7:0] tx, input logic [7:0] dev, input int mode);
        bit   ok = 0;
        bit   dlv;
        bit   to;
        txe_t e;
        rxe_t r;
        TxData  = tx;
        TxValid = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (TxReady) begin
                ok = 1;
                break;
            end
        end
        chk("handshake", ok, 1);
        @(posedge Clk); #1;
        TxValid  = 0;
        TxData   = 8'($urandom);
        dev_cur  = dev;
        dev_idx  = 0;
        rise_cnt = 0;
        nbits    = 0;
        mosi     = 8'h00;
        e.tx      = tx;
        e.div     = m_div;
        e.aborted = (mode == 2);
        e.len     = (mode == 2) ? 10 * (m_div + 1) :
                    (mode == 1) ? 16 * (m_div + 1) + 10 - m_div : 16 * (m_div + 1);
        tx_exp.push_back(e);
        dlv = 0;
        to  = 0;
        if (mode == 2) begin
            m_token = 0;
            m_cnt   = 0;
        end else if (!m_wm || m_token) begin
            dlv = 1;
            m_cnt = 0;
        end else if (dev != 8'hFF) begin
            dlv = 1;
            m_token = 1;
            m_cnt   = 0;
        end else begin
`ifdef SPI_PHY_TIMEOUT_EN
            if (m_cnt == TO) begin
                dlv = 1;
                to  = 1;
                m_cnt = 0;
            end else m_cnt++;
`endif
        end
        if (dlv) begin
            r.d  = dev;
            r.to = to;
            rx_exp.push_back(r);
        end
        if (mode == 1) begin
            poll(0, 2);
            ClockStretch = 1;
            repeat (10) @(posedge Clk);
            #1 ClockStretch = 0;
        end else if (mode == 2) begin
            poll(1, 5);
            Abort = 1;
            @(posedge Clk); #1;
            Abort = 0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wdev[5];
        int         n, r;
        bit         wm;
        Reset = 1; TxData = 0; TxValid = 0; WaitMode = 0; Abort = 0;
        Divider = 0; ClockStretch = 0;
        #12;
        chk("reset_txready", TxReady, 1);
        chk("reset_rxvalid", RxValid, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_timeouterr", TimeoutErr, 0);
        chk("reset_rxdata", RxData, 8'h00);
        chk("reset_spido", SPIDo, 1);
        chk("reset_spiclk", SPIClk, 0);
        @(posedge Clk); #1 Reset = 0;

        begin_group(0, 0);
        send(8'hAB, 8'h3E, 0);
        begin_group(3, 0);
        send(8'hCD, 8'($urandom), 0);
        send(8'h12, 8'($urandom), 0);
        idle_abort();
        begin_group(1, 1);
        wdev = '{8'hFF, 8'hFF, 8'hFF, 8'h53, 8'h85};
        for (int i = 0; i < 5; i++) send(8'($urandom), wdev[i], 0);
        begin_group(2, 0);
        send(8'h5A, 8'hC3, 1);
        begin_group(1, 0);
        send(8'h96, 8'h69, 2);
        send(8'h3C, 8'hA5, 0);
        begin_group(0, 0);
        idle_abort();
        begin_group(0, 1);
        for (int i = 0; i < 6; i++) send(8'($urandom), 8'hFF, 0);

        for (int g = 0; g < 14; g++) begin
            wm = 1'($urandom);
            begin_group(int'($urandom_range(0, 5)), wm);
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) begin
                r = int'($urandom_range(0, 7));
                send(8'($urandom), (wm && $urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom),
                     (r == 0) ? 1 : (r == 1) ? 2 : 0);
            end
            if ($urandom_range(0, 3) == 0) idle_abort();
        end

        // Reset in the middle of a byte
        begin_group(2, 0);
        send(8'h77, 8'h88, 0);
        poll(1, 3);
        Reset = 1;
        #1;
        chk("midreset_spiclk", SPIClk, 0);
        chk("midreset_busy", Busy, 0);
        chk("midreset_rxvalid", RxValid, 0);
        chk("midreset_rxdata", RxData, 8'h00);
        tx_exp.delete();
        rx_exp.delete();
        m_token = 0;
        m_cnt   = 0;
        @(posedge Clk); #1 Reset = 0;
        begin_group(0, 0);
        send(8'hE7, 8'h1B, 0);
        drain();
        chk("final_spiclk", SPIClk, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_byte_phy.md
Name: spi_byte_phy

Overview:
- Bit-level SPI serializer/deserializer, mode 0, MSB first.
- Sits directly downstream of the SPI buffer controller. The controller hands it one byte at a time over a valid/ready handshake.
- Drives SPIDo/SPIClk to the device pin mux and samples SPIDi.
- Provides programmable clock division, clock stretching, abort, and a "wait for token" filter that drops 0xFF idle bytes.

Parameters:
- DIV_W, 8, width of the clock divider input.
- TIMEOUT_BYTES, 1024, number of consecutive discarded 0xFF bytes before timeout. Used only with SPI_PHY_TIMEOUT_EN.

Ports:
- Clk  in  1  transfer clock (output of the clock mux).
- Reset  in  1  asynchronous, active-high reset.
- TxData  in  8  byte to shift out.
- TxValid  in  1  TxData is valid.
- TxReady  out  1  phy can accept a byte.
- WaitMode  in  1  discard received 0xFF bytes until the first non-0xFF byte.
- Abort  in  1  terminate the current byte.
- Divider  in  DIV_W  SPI half-period = Divider+1 Clk cycles.
- ClockStretch  in  1  hold SPIClk low.
- RxData  out  8  last received byte.
- RxValid  out  1  one-cycle pulse, RxData valid.
- Busy  out  1  a byte is in flight.
- TimeoutErr  out  1  one-cycle pulse when the wait timeout fires.
- SPIDo  out  1  serial data out.
- SPIDi  in  1  serial data in.
- SPIClk  out  1  serial clock, idles low.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous, active-high.
- Reset values:
  - TxReady=1, RxValid=0, Busy=0, TimeoutErr=0.
  - RxData=8'h00, SPIDo=1, SPIClk=0.
  - Internal "token found" flag=0. Bit counter=0. Divider counter=0.
- States: IDLE, LOW, HIGH.
- IDLE:
  - TxReady=1, SPIClk=0, Busy=0.
  - On TxValid&&TxReady: latch TxData and Divider. Next cycle SPIDo=TxData[7] and the state is LOW.
  - Divider changes take effect only at byte start.
- LOW:
  - SPIClk=0. The divider counter counts 0..Divider.
  - At terminal count, if ClockStretch=1: counter holds at terminal and SPIClk stays low.
  - At terminal count, if ClockStretch=0: go to HIGH. SPIClk rises, and SPIDi is sampled into the shift register on the same Clk edge.
- HIGH:
  - SPIClk=1, counted for Divider+1 cycles. At terminal count SPIClk falls.
  - If bits sent < 8: shift, present the next bit on SPIDo, go to LOW.
  - After the 8th high phase: go to IDLE and SPIDo=1.
- Byte timing:
  - Unstretched byte = 16*(Divider+1) Clk cycles from the first LOW cycle to the return to IDLE.
  - Minimum one IDLE cycle between bytes.
- Receive:
  - The 8th sample completes the byte in the cycle SPIClk falls.
  - RxData updates and RxValid pulses for exactly 1 cycle, coincident with the return to IDLE.
- WaitMode:
  - While WaitMode=1 and token found=0, a received 0xFF produces no RxValid.
  - The first non-0xFF byte sets token found, and that byte is delivered.
  - Token found clears when WaitMode=0 or on Abort.
  - WaitMode=0 delivers every byte.
- Abort:
  - Sampled in LOW or HIGH.
  - A HIGH phase completes its count. The block then goes to IDLE with SPIClk=0.
  - No RxValid; the partial byte is dropped.
  - Abort in IDLE is ignored, except that it clears token found.
  - Abort has priority over ClockStretch.
- Busy = state != IDLE.
- Divider=0: SPIClk toggles every Clk cycle, i.e. Clk/2.
- Reset mid-byte: SPIClk drops to 0 immediately (asynchronous) and no RxValid is produced.

Optional Feature:
- Macro: SPI_PHY_TIMEOUT_EN.
- Defined:
  - A counter of consecutive discarded 0xFF bytes runs in WaitMode; it is cleared by any delivered byte, by Abort, or by WaitMode=0.
  - When TIMEOUT_BYTES bytes have been discarded, the next 0xFF is delivered with RxValid, TimeoutErr pulses in the same cycle, and the counter clears.
- Not defined: TimeoutErr is tied 0 and waiting is unbounded.

Test Plan:
- Divider=0, send 0xAB while SPIDi returns 0x3E:
  - SPIDo carries 1010_1011 on rising edges and RxData=0x3E.
  - RxValid pulses once, 16 cycles after the first LOW cycle.
- Divider=3, back-to-back TxValid with 0xCD then 0x12:
  - Each byte takes 64 cycles, with at least a 1-cycle IDLE gap.
  - Half-periods measure 4 cycles.
- WaitMode=1, device returns FF,FF,FF,53,85:
  - RxValid pulses only for 0x53 and 0x85.
- ClockStretch held high for 10 cycles during the 3rd LOW phase:
  - SPIClk stays low for those cycles and the byte is otherwise intact.
- Abort asserted in the 5th HIGH phase:
  - SPIClk returns low, the state is IDLE, and there is no RxValid.
  - A subsequent byte transfers correctly.
- (SPI_PHY_TIMEOUT_EN, TIMEOUT_BYTES=4) WaitMode with an all-0xFF device:
  - The 5th byte produces RxValid with RxData=0xFF and a TimeoutErr pulse.
